systolic_feeder: RTL and testbench

Input skew stage directly upstream of the PE array. It accepts one activation vector per cycle over a valid/ready handshake, one element per array row. Each row is delayed by its row index so that data enters the array as a diagonal wavefront, and it drives every row's `in_left` together with a matching per-row `go`. A small controller sequences a pass of `num_cols` vectors, drains the skew pipeline, and pulses `done`.

---
 rtl/systolic_feeder.sv | 152 +++++++++++++++
 tb/tb_systolic_feeder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder
//
// Input skew stage for the PE array. Accepts one activation vector per cycle
// over a valid/ready handshake and delays row r by r cycles. The result is
// that the array sees a diagonal wavefront. Each row's element is presented
// together with a matching per-row go strobe. A small controller runs a pass
// of num_cols vectors, flushes the skew pipeline and then pulses done.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous reset, active low (0 = reset)
//   start      one-cycle pulse beginning a pass (honoured only when idle)
//   num_cols   vectors in the pass, sampled on the accepted start
//   act_valid  upstream vector valid
//   act_ready  feeder can accept a vector (registered state decode)
//   act_data   row r element at [r*DATA_W +: DATA_W]
//   left_data  to PE row r in_left, same packing
//   go         bit r strobes every PE in row r
//   busy       pass in progress
//   done       one-cycle pulse at the end of a pass
//   bubble_cnt (only with FEEDER_BUBBLE_CNT_EN) saturating count of FEED
//              cycles where the feeder was ready but upstream was not valid
//
// Build option: define FEEDER_BUBBLE_CNT_EN to add the bubble_cnt port.

module systolic_feeder #(
  parameter int ROWS   = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               num_cols,
  input  logic                     act_valid,
  output logic                     act_ready,
  input  logic [ROWS*DATA_W-1:0]   act_data,
  output logic [ROWS*DATA_W-1:0]   left_data,
  output logic [ROWS-1:0]          go,
  output logic                     busy,
  output logic                     done
`ifdef FEEDER_BUBBLE_CNT_EN
  ,
  output logic [15:0]              bubble_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  // The last row's final stage is loaded ROWS-1 cycles after the last
  // transfer. done is raised one cycle later, so DRAIN spans ROWS edges.
  localparam logic [7:0] DRAIN_LAST = 8'(ROWS - 1);

  state_t     state;
  logic [7:0] cols_left;
  logic [7:0] accepted;
  logic [7:0] drain_cnt;
  logic       xfer;

  assign xfer = act_valid & act_ready;

  // Controller. busy is kept high through the done cycle. It drops on the
  // following edge, so busy and done fall together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cols_left <= '0;
      accepted  <= '0;
      drain_cnt <= '0;
      act_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy      <= 1'b0;
          act_ready <= 1'b0;
          if (start) begin
            state     <= FEED;
            cols_left <= num_cols;
            accepted  <= '0;
            busy      <= 1'b1;
            act_ready <= (num_cols != 8'd0);
          end
        end
        FEED: begin
          if (cols_left == 8'd0) begin
            // Empty pass: nothing entered the pipeline, so finish at once.
            done  <= 1'b1;
            state <= IDLE;
          end else if (xfer) begin
            accepted <= accepted + 8'd1;
            if (accepted + 8'd1 == cols_left) begin
              state     <= DRAIN;
              act_ready <= 1'b0;
              drain_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            drain_cnt <= drain_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Skew chains. Row r has r+1 stages. Non-transfer cycles push a zero
  // bubble, so an idle row always shows data 0 with go low.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_W-1:0] sdata [r+1];
    logic [r:0]        svld;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        svld <= '0;
        for (int s = 0; s <= r; s++) sdata[s] <= '0;
      end else begin
        svld[0]  <= xfer;
        sdata[0] <= xfer ? act_data[r*DATA_W +: DATA_W] : '0;
        for (int s = 1; s <= r; s++) begin
          svld[s]  <= svld[s-1];
          sdata[s] <= sdata[s-1];
        end
      end
    end

    assign go[r]                          = svld[r];
    assign left_data[r*DATA_W +: DATA_W]  = sdata[r];
  end

`ifdef FEEDER_BUBBLE_CNT_EN
  // Counts upstream stalls during FEED. The counter saturates instead of
  // wrapping. It holds its value after done until the next accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= '0;
    end else if (state == IDLE && start) begin
      bubble_cnt <= '0;
    end else if (state == FEED && act_ready && !act_valid &&
                 bubble_cnt != 16'hFFFF) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder
//
// Bench for systolic_feeder with ROWS=4 and DATA_W=8. Each accepted vector
// pushes one expected {row, cycle, data} entry per row into a scoreboard.
// The negedge monitor pops each entry on the cycle it is due. It also checks
// that idle rows show go=0 and data=0, and checks done, busy and act_ready
// against the bench's own expectations. A table of passes covers the main
// cases. Hand-written sequences cover reset behaviour and reset during DRAIN.

module tb_systolic_feeder;

  localparam int ROWS   = 4;
  localparam int DATA_W = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   start = 1'b0;
  logic [7:0]             num_cols = '0;
  logic                   act_valid = 1'b0;
  logic                   act_ready;
  logic [ROWS*DATA_W-1:0] act_data = '0;
  logic [ROWS*DATA_W-1:0] left_data;
  logic [ROWS-1:0]        go;
  logic                   busy;
  logic                   done;
`ifdef FEEDER_BUBBLE_CNT_EN
  logic [15:0]            bubble_cnt;
`endif

  always #5 clk = ~clk;

  systolic_feeder #(.ROWS(ROWS), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_cols  (num_cols),
    .act_valid (act_valid),
    .act_ready (act_ready),
    .act_data  (act_data),
    .left_data (left_data),
    .go        (go),
    .busy      (busy),
`ifdef FEEDER_BUBBLE_CNT_EN
    .done      (done),
    .bubble_cnt(bubble_cnt)
`else
    .done      (done)
`endif
  );

  typedef struct {
    int                row;
    int                cyc;
    logic [DATA_W-1:0] data;
  } exp_t;

  typedef struct {
    logic [7:0]  n;
    logic [31:0] vpat;
    logic [31:0] first;
    int          restart_at;
    int          exp_xfers;
    int          exp_bubbles;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[6];

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_done_cyc = -1;
  int   go_count = 0;
  logic exp_ready = 1'b0;
  logic exp_busy = 1'b0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] required);
    n_cmp++;
    if (actual !== required) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  // Negedge monitor: compares every output with what is due this cycle.
  always @(negedge clk) begin
    logic              exp_go;
    logic [DATA_W-1:0] exp_d;
    if (mon_en) begin
      for (int r = 0; r < ROWS; r++) begin
        exp_go = 1'b0;
        exp_d  = '0;
        for (int i = 0; i < sbq.size(); i++) begin
          if (sbq[i].row == r && sbq[i].cyc == cyc) begin
            exp_go = 1'b1;
            exp_d  = sbq[i].data;
            sbq.delete(i);
            break;
          end
        end
        check_output($sformatf("row%0d_go", r), 64'(go[r]), 64'(exp_go));
        check_output($sformatf("row%0d_data", r), 64'(left_data[r*DATA_W +: DATA_W]), 64'(exp_d));
      end
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].cyc < cyc) begin
          n_cmp++;
          n_bad++;
          $display("[TB] FAIL overdue row%0d: got nothing, want data %0h at cycle %0d",
                   sbq[i].row, sbq[i].data, sbq[i].cyc);
          sbq.delete(i);
        end
      end
      check_output("done", 64'(done), 64'(cyc == exp_done_cyc));
      check_output("busy", 64'(busy), 64'(exp_busy));
      check_output("act_ready", 64'(act_ready), 64'(exp_ready));
      if (go[ROWS-1]) go_count++;
    end
  end

  // Drives one cycle of inputs and returns #1 after the sampling edge.
  task automatic apply_stimulus(input logic s, input logic [7:0] n,
                                input logic v, input logic [31:0] d);
    start     = s;
    num_cols  = n;
    act_valid = v;
    act_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input vec_t t);
    int xfers;
    int c;
    logic v;
    logic [31:0] d;
    xfers    = 0;
    c        = 0;
    go_count = 0;
    apply_stimulus(1'b1, t.n, 1'b0, '0);
    start     = 1'b0;
    exp_busy  = 1'b1;
    exp_ready = (t.n != 8'd0);
`ifdef FEEDER_BUBBLE_CNT_EN
    check_output("bubble_clear", 64'(bubble_cnt), 64'd0);
`endif
    if (t.n == 8'd0) exp_done_cyc = cyc + 1;
    while (xfers < int'(t.n) && c < 64) begin
      v = (c < 32) ? t.vpat[c] : 1'b1;
      d = (xfers == 0 && t.first != 0) ? t.first : $urandom;
      apply_stimulus(c == t.restart_at, (c == t.restart_at) ? 8'd9 : t.n, v, d);
      if (v) begin
        for (int r = 0; r < ROWS; r++)
          sbq.push_back('{row: r, cyc: cyc + r, data: d[r*DATA_W +: DATA_W]});
        xfers++;
        if (xfers == int'(t.n)) begin
          exp_ready    = 1'b0;
          exp_done_cyc = cyc + ROWS;
        end
      end
      c++;
    end
    start     = 1'b0;
    act_valid = 1'b0;
    for (int k = 0; k < 64 && cyc <= exp_done_cyc; k++) begin
      @(posedge clk);
      #1;
    end
    exp_busy = 1'b0;
    check_output("go_count", 64'(go_count), 64'(t.exp_xfers));
`ifdef FEEDER_BUBBLE_CNT_EN
    check_output("bubble_cnt", 64'(bubble_cnt), 64'(t.exp_bubbles));
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d;
    tbl[0] = '{n: 8'd1, vpat: 32'hFFFF_FFFF, first: 32'h0403_0201, restart_at: -1, exp_xfers: 1, exp_bubbles: 0};
    tbl[1] = '{n: 8'd3, vpat: 32'hFFFF_FFFD, first: 32'h0,         restart_at: -1, exp_xfers: 3, exp_bubbles: 1};
    tbl[2] = '{n: 8'd0, vpat: 32'hFFFF_FFFF, first: 32'h0,         restart_at: -1, exp_xfers: 0, exp_bubbles: 0};
    tbl[3] = '{n: 8'd3, vpat: 32'hFFFF_FFFF, first: 32'h0,         restart_at: 1,  exp_xfers: 3, exp_bubbles: 0};
    tbl[4] = '{n: 8'd2, vpat: 32'hFFFF_FFE0, first: 32'h0,         restart_at: -1, exp_xfers: 2, exp_bubbles: 5};
    tbl[5] = '{n: 8'd8, vpat: 32'hAAAA_AAAA, first: 32'h0,         restart_at: -1, exp_xfers: 8, exp_bubbles: 8};

    // Reset held with valid asserted: everything must stay quiet.
    mon_en = 1'b1;
    rst    = 1'b0;
    repeat (3) apply_stimulus(1'b0, 8'd0, 1'b1, 32'hDEAD_BEEF);
    rst = 1'b1;
    // Out of reset without start: still no ready and no go.
    repeat (3) apply_stimulus(1'b0, 8'd0, 1'b1, 32'hCAFE_F00D);
    act_valid = 1'b0;

    for (int i = 0; i < 6; i++) run_pass(tbl[i]);

    // Reset during DRAIN: no done, outputs cleared, then a fresh pass.
    apply_stimulus(1'b1, 8'd2, 1'b0, '0);
    start     = 1'b0;
    exp_busy  = 1'b1;
    exp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      d = $urandom;
      apply_stimulus(1'b0, 8'd2, 1'b1, d);
      for (int r = 0; r < ROWS; r++)
        sbq.push_back('{row: r, cyc: cyc + r, data: d[r*DATA_W +: DATA_W]});
    end
    exp_ready = 1'b0;
    exp_done_cyc = cyc + ROWS;
    apply_stimulus(1'b0, 8'd2, 1'b0, '0);
    #1;
    rst = 1'b0;
    sbq.delete();
    exp_busy     = 1'b0;
    exp_done_cyc = -1;
    #1;
    check_output("rst_left_data", 64'(left_data), 64'd0);
    check_output("rst_go", 64'(go), 64'd0);
    repeat (2) apply_stimulus(1'b0, 8'd0, 1'b0, '0);
    rst = 1'b1;
    apply_stimulus(1'b0, 8'd0, 1'b0, '0);
    run_pass(tbl[1]);

    repeat (2) apply_stimulus(1'b0, 8'd0, 1'b0, '0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
